// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I format codes, opcode constants and encoder entry type
// Shared with the decode side so both agree on the format and opcode encodings.
package rv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_OP  = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } enc_entry_t;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// rtl/instr_encoder_imm_pack.sv - places immediate bits per format; range check under IMM_RANGE_CHECK_EN
// Combinational; bits_o holds only the immediate positions, all others zero.
module imm_pack
  import rv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [31:0] imm_i,
  output logic [31:0] bits_o,
  output logic        err_o
);

  always_comb begin
    bits_o = '0;
    case (fmt_i)
      FMT_I:   bits_o = {imm_i[11:0], 20'b0};
      FMT_S:   bits_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
      FMT_B:   bits_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
      FMT_U:   bits_o = {imm_i[31:12], 12'b0};
      FMT_J:   bits_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
      default: bits_o = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // A value fits in an N-bit signed field when everything above bit N-2 is pure sign.
  logic fits12, fits13, fits21;
  assign fits12 = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
  assign fits13 = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
  assign fits21 = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

  always_comb begin
    err_o = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: err_o = !fits12;
      FMT_B:        err_o = !fits13 || imm_i[0];
      FMT_J:        err_o = !fits21 || imm_i[0];
      FMT_U:        err_o = (imm_i[11:0] != '0);
      default:      err_o = 1'b0;
    endcase
  end
`else
  logic unused_imm;
  assign unused_imm = imm_i[0];
  assign err_o      = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-bundle encoder with address tagging and 2-entry skid FIFO
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
  import rv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        addr_load,
  input  logic [31:0] addr_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  logic [31:0] imm_bits;
  logic        range_err;
  logic [31:0] word;
  logic        illegal;

  imm_pack u_imm_pack (
    .fmt_i  (in_fmt),
    .imm_i  (in_imm),
    .bits_o (imm_bits),
    .err_o  (range_err)
  );

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (in_fmt)
      FMT_R:        word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I:        word = imm_bits | {12'b0, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S, FMT_B: word = imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode};
      FMT_U, FMT_J: word = imm_bits | {20'b0, in_rd, in_opcode};
      default: begin
        word    = NOP_WORD;
        illegal = 1'b1;
      end
    endcase
  end

  enc_entry_t  mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        in_ready_q;
  logic [31:0] addr_q, addr_d;
  logic        push, pop;
  enc_entry_t  new_entry;

  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;
  assign new_entry = '{instr: word, addr: addr_q, err: illegal | range_err};

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
  end

  // A load on the accept cycle overrides the increment; the bundle already took addr_q.
  always_comb begin
    addr_d = addr_q;
    if (addr_load) addr_d = addr_val;
    else if (push) addr_d = addr_q + 32'(ADDR_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      addr_q     <= BASE_ADDR;
    end else begin
      if (push) mem_q[wr_ptr_q] <= new_entry;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      count_q    <= count_d;
      // Registered from next occupancy so out_ready never reaches in_ready combinationally.
      in_ready_q <= (count_d != 2'd2);
      addr_q     <= addr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = mem_q[rd_ptr_q].instr;
  assign out_addr  = mem_q[rd_ptr_q].addr;
  assign out_err   = mem_q[rd_ptr_q].err;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, address the write-address counter takes at reset.
REQ-002 SHALL provide parameter ADDR_STEP, default 4, counter increment per accepted instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port in_valid  input  1  field bundle valid.
REQ-006 SHALL have port in_ready  output  1  encoder can accept a bundle.
REQ-007 SHALL have port in_fmt  input  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6-7 illegal.
REQ-008 SHALL have ports in_opcode 7, in_rd 5, in_rs1 5, in_rs2 5, in_funct3 3, in_funct7 7, all inputs, raw instruction fields.
REQ-009 SHALL have port in_imm  input  32  signed byte-offset or value immediate, unencoded.
REQ-010 SHALL have port addr_load  input  1 and addr_val  input  32  counter load request and value.
REQ-011 SHALL have port out_valid  output  1 and out_ready  input  1  output handshake.
REQ-012 SHALL have ports out_instr  output  32, out_addr  output  32, out_err  output  1  encoded word, its memory address, range-error flag.

Function
REQ-013 SHALL transfer on a port when valid and ready are both high at a rising edge; no combinational path from out_ready to in_ready.
REQ-014 SHALL place immediate bits exactly inverse to RV32I decode: I imm[11:0] to [31:20]; S imm[11:5] to [31:25] and imm[4:0] to [11:7]; B imm[12|10:5] to [31:25] and imm[4:1|11] to [11:7]; U imm[31:12] to [31:12]; J imm[20|10:1|11|19:12] to [31:12].
REQ-015 SHALL insert only the fields each format defines (R: funct7, rs2, rs1, funct3, rd, opcode; U/J: no rs/funct fields).
REQ-016 SHALL emit illegal formats 6-7 as 32'h0000_0013 (NOP) with out_err=1.
REQ-017 SHALL have 1-cycle latency: a bundle accepted at edge N is presented with out_valid=1 after edge N when the buffer is empty.
REQ-018 SHALL buffer in a 2-entry FIFO (skid); in_ready=0 only when both entries hold data; sustain 1 instruction/cycle when out_ready stays 1.
REQ-019 SHALL hold out_instr/out_addr/out_err stable while out_valid=1 and out_ready=0.
REQ-020 SHALL tag each accepted bundle with the current counter value, then advance it by ADDR_STEP, wrapping modulo 2^32.
REQ-021 SHALL, on addr_load=1, set the counter to addr_val; on simultaneous accept, the accepted bundle takes the pre-load value and the load wins over the increment.
REQ-022 SHALL accept and drain simultaneously when full and out_ready=1 (in_ready stays 0 that cycle; occupancy unchanged on a same-cycle push/pop when not full).

Reset
REQ-023 SHALL, with rst=1, clear both FIFO entries, drive out_valid=0, out_instr=0, out_addr=0, out_err=0, in_ready=0, counter=BASE_ADDR.
REQ-024 SHALL discard any buffered bundles when rst asserts mid-operation; in_ready=1 the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with IMM_RANGE_CHECK_EN defined, set out_err when imm is out of range: I/S outside -2048..2047; B outside -4096..4094 or odd; J outside -1048576..1048574 or odd; U with imm[11:0] nonzero; the word is still emitted with truncated bits.
REQ-026 SHALL, without IMM_RANGE_CHECK_EN, never set out_err except for illegal formats, with no range-check logic synthesized.

Structure
REQ-027 SHALL take format codes and opcode constants (OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, NOP word) from the shared package rv_pkg, also used by the decode side.
REQ-028 SHALL implement field packing as combinational sub-module imm_pack (fmt and imm in, placed bits and range error out); the FIFO and counter live in instr_encoder.

Verification
REQ-029 SHALL check fmt=I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr 0x00500093, out_addr 0x0 one cycle after accept.
REQ-030 SHALL check fmt=S, opcode 0x23, rs1=1, rs2=2, funct3=2, imm=8 -> 0x0020A423, out_addr 0x4.
REQ-031 SHALL check fmt=B beq x0,x0 imm=-4 -> 0xFE000EE3; fmt=J rd=1 imm=8 -> 0x008000EF; fmt=U rd=5 imm=0x12345000 -> 0x123452B7.
REQ-032 SHALL check out_ready=0 for 3 cycles with back-to-back input -> in_ready drops after 2 accepts, outputs held stable, order preserved, no loss.
REQ-033 SHALL check addr_load with addr_val=0xFFFF_FFFC plus two accepts -> addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-034 SHALL check, with IMM_RANGE_CHECK_EN defined, fmt=I imm=2048 -> out_err=1; fmt=B imm=3 -> out_err=1; rst mid-stream -> out_valid=0 next cycle.
